intr_arbiter: RTL and testbench
===============================

// Module: intr_arbiter
// PURPOSE
//  Parametrised interrupt arbiter between NREQ device request lines and the CPU.
//  Masks each request against the current processor priority (ipl) and picks the winner:
//   highest level, ties to lowest index.
//  Offers the winner's level/vector to the CPU, then completes a req/ack/grant handshake.
//  Supports edge (latched) or level request mode.
//  Sits between the bus request lines and the CPU trap sequencer.
// PARAMETERS
//  NREQ   8  number of request sources
//  LVL_W  3  priority level width (levels 0..2**LVL_W-1)
//  VEC_W  8  vector width per source
//  EDGE   0  0 = level-sensitive sources, 1 = rising-edge latched sources
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high reset
//  ipl         in   LVL_W        current processor priority
//  src_req     in   NREQ         per-source request
//  src_level   in   NREQ*LVL_W   per-source level; source i in [i*LVL_W +: LVL_W]
//  src_vector  in   NREQ*VEC_W   per-source vector; source i in [i*VEC_W +: VEC_W]
//  cpu_ack     in   1            CPU accepts the offered interrupt
//  int_req     out  1            interrupt offered to CPU
//  int_level   out  LVL_W        level of the offered interrupt
//  int_vector  out  VEC_W        vector of the offered interrupt
//  int_src     out  clog2(NREQ)  index of the offered source
//  src_grant   out  NREQ         one-hot, one-cycle grant pulse to the winning source
// BEHAVIOUR
//  Reset: state=IDLE; pending, int_req, int_level, int_vector, int_src and src_grant all 0.
//  Pending register:
//   - EDGE=0: pending <= src_req every cycle.
//   - EDGE=1: bit set on a 0->1 edge of src_req, cleared on its grant.
//   - Edge detection uses a registered copy of src_req, reset to 0.
//   - A set and a clear in the same cycle: the set wins.
//  Eligibility:
//   - Source i is eligible iff pending[i] && level_i > ipl (strict compare).
//   - Level 0 therefore never wins; ipl=max masks all sources.
//  Winner: maximum level among eligible sources; ties go to the lowest index.
//  FSM IDLE/OFFER/GRANT; all outputs registered.
//   - IDLE: if any source is eligible, latch winner idx/level/vector, set int_req=1,
//     go to OFFER.
//   - OFFER: winner is frozen; no preemption by higher requests.
//     - cpu_ack=1: int_req<=0, src_grant[idx]<=1 for one cycle, pending[idx] cleared
//       (EDGE=1), go to GRANT.
//     - else, if the winner is no longer eligible (request dropped, or ipl>=level):
//       withdraw (int_req<=0), go to IDLE.
//     - ack and withdraw in the same cycle: ack wins.
//   - GRANT: src_grant<=0, go to IDLE.
//     - The dead cycle lets the source drop its request before re-arbitration.
//  cpu_ack outside OFFER is ignored.
//  int_level/int_vector/int_src hold their last value after deassert.
//  Latency:
//   - src_req rising at edge n -> pending at n+1 -> int_req high after edge n+2.
//   - cpu_ack sampled at edge m -> src_grant high for cycle m..m+1 -> earliest new
//     int_req after edge m+2.
//  Reset mid-handshake: immediate return to the reset state; pending requests are lost
//   (EDGE=1) and must be re-edged.
//  Vector/level are sampled once at the IDLE->OFFER transition; later changes are ignored.
// STRUCTURE
//  intr_defs.vh: FSM state encodings (ST_IDLE=2'd0, ST_OFFER=2'd1, ST_GRANT=2'd2), clog2 function.
//  Sub-module intr_prio_sel: combinational; pending, levels, ipl -> any, idx, level.
//   - Reused by the OFFER eligibility check via index compare.
//  Top: pending/edge logic, FSM, output registers.
// TESTING
//  1. reset 3 cycles, all src_req=0 -> int_req=0, src_grant=0, state IDLE.
//  2. ipl=3, src3 lvl5 vec 8'h30 req -> int_req=1, level=5, vector=8'h30, src=3 after 2 edges;
//     cpu_ack 1 cycle -> src_grant=8'b0000_1000 for exactly 1 cycle.
//  3. ipl=0, src1 lvl4 and src6 lvl4 same cycle -> int_src=1; after grant, if src1 drops,
//     next offer is src6.
//  4. ipl=4, src2 lvl4 -> never offered; ipl->3 -> offered in 2 cycles;
//     in OFFER raise ipl to 6 with no ack -> int_req falls next cycle.
//  5. EDGE=1: src5 pulses 1 cycle at lvl 7 with ipl=7 -> not offered; ipl->0 -> offered;
//     ack -> granted; no re-offer.
//  6. OFFER with cpu_ack=1 and src_req dropping in same cycle -> grant still issued;
//     reset asserted in GRANT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/intr_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encodings and a
// constant-evaluable clog2 used to size the source index.
package intr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational priority selector: masks pending sources against ipl and
// returns the highest-level eligible source, ties resolved to the lowest index.
module intr_prio_sel
  import intr_arbiter_pkg::*;
#(
  parameter int NREQ  = 8,
  parameter int LVL_W = 3,
  parameter int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]       pending_i,
  input  logic [NREQ*LVL_W-1:0] levels_i,
  input  logic [LVL_W-1:0]      ipl_i,
  output logic                  any_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [LVL_W-1:0]      level_o
);

  logic [LVL_W-1:0] lvl  [NREQ];
  logic [NREQ-1:0]  elig;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign lvl[gi]  = levels_i[gi*LVL_W +: LVL_W];
    assign elig[gi] = pending_i[gi] && (lvl[gi] > ipl_i);
  end

  // Strict '>' on the running best keeps the earliest index on equal levels.
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    level_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i] && (!any_o || lvl[i] > level_o)) begin
        any_o   = 1'b1;
        idx_o   = IDX_W'(i);
        level_o = lvl[i];
      end
    end
  end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: pending/edge capture, priority selection and the
// IDLE/OFFER/GRANT handshake towards the CPU, all outputs registered.
module intr_arbiter
  import intr_arbiter_pkg::*;
#(
  parameter int NREQ  = 8,
  parameter int LVL_W = 3,
  parameter int VEC_W = 8,
  parameter int EDGE  = 0,
  localparam int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LVL_W-1:0]      ipl,
  input  logic [NREQ-1:0]       src_req,
  input  logic [NREQ*LVL_W-1:0] src_level,
  input  logic [NREQ*VEC_W-1:0] src_vector,
  input  logic                  cpu_ack,
  output logic                  int_req,
  output logic [LVL_W-1:0]      int_level,
  output logic [VEC_W-1:0]      int_vector,
  output logic [IDX_W-1:0]      int_src,
  output logic [NREQ-1:0]       src_grant
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic             int_req_q, int_req_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [NREQ-1:0]  grant_q, grant_d;

  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [LVL_W-1:0] sel_level;
  logic [VEC_W-1:0] vec [NREQ];
  logic             still_elig;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_vec
    assign vec[gi] = src_vector[gi*VEC_W +: VEC_W];
  end

  intr_prio_sel #(
    .NREQ  (NREQ),
    .LVL_W (LVL_W),
    .IDX_W (IDX_W)
  ) u_sel (
    .pending_i (pending_q),
    .levels_i  (src_level),
    .ipl_i     (ipl),
    .any_o     (sel_any),
    .idx_o     (sel_idx),
    .level_o   (sel_level)
  );

  // Edge mode: a new rising edge overrides a same-cycle clear from the grant.
  if (EDGE != 0) begin : g_edge
    logic [NREQ-1:0] req_prev_q;
    always_ff @(posedge clk) begin
      if (reset) req_prev_q <= '0;
      else       req_prev_q <= src_req;
    end
    assign pending_d = (pending_q & ~grant_d) | (src_req & ~req_prev_q);
  end else begin : g_level
    assign pending_d = src_req;
  end

  // The offered source stays valid only while still pending above ipl at its latched level.
  assign still_elig = pending_q[src_q] && (level_q > ipl);

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    level_d   = level_q;
    vector_d  = vector_q;
    src_d     = src_q;
    grant_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          state_d   = ST_OFFER;
          int_req_d = 1'b1;
          src_d     = sel_idx;
          level_d   = sel_level;
          vector_d  = vec[sel_idx];
        end
      end
      ST_OFFER: begin
        if (cpu_ack) begin
          state_d          = ST_GRANT;
          int_req_d        = 1'b0;
          grant_d[src_q]   = 1'b1;
        end else if (!still_elig) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      int_req_q <= 1'b0;
      level_q   <= '0;
      vector_q  <= '0;
      src_q     <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_req_q <= int_req_d;
      level_q   <= level_d;
      vector_q  <= vector_d;
      src_q     <= src_d;
      grant_q   <= grant_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_level  = level_q;
  assign int_vector = vector_q;
  assign int_src    = src_q;
  assign src_grant  = grant_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: one level-mode and one edge-mode instance
// share stimulus; each scenario task checks the relevant instance inline.
module tb_intr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ipl;
  logic [7:0]  src_req;
  logic [23:0] src_level;
  logic [63:0] src_vector;
  logic        cpu_ack;

  logic       a_int_req, b_int_req;
  logic [2:0] a_int_level, b_int_level;
  logic [7:0] a_int_vector, b_int_vector;
  logic [2:0] a_int_src, b_int_src;
  logic [7:0] a_src_grant, b_src_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intr_arbiter #(.NREQ(8), .LVL_W(3), .VEC_W(8), .EDGE(0)) dut_lvl (
    .clk(clk), .reset(reset), .ipl(ipl), .src_req(src_req),
    .src_level(src_level), .src_vector(src_vector), .cpu_ack(cpu_ack),
    .int_req(a_int_req), .int_level(a_int_level), .int_vector(a_int_vector),
    .int_src(a_int_src), .src_grant(a_src_grant)
  );

  intr_arbiter #(.NREQ(8), .LVL_W(3), .VEC_W(8), .EDGE(1)) dut_edge (
    .clk(clk), .reset(reset), .ipl(ipl), .src_req(src_req),
    .src_level(src_level), .src_vector(src_vector), .cpu_ack(cpu_ack),
    .int_req(b_int_req), .int_level(b_int_level), .int_vector(b_int_vector),
    .int_src(b_int_src), .src_grant(b_src_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_req = '0; cpu_ack = 1'b0; ipl = '0;
    src_level = '0; src_vector = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req got=%0h exp=0", a_int_req); end
    total++; if (a_src_grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%0h exp=0", a_src_grant); end
    total++; if ({a_int_level, a_int_vector, a_int_src} !== 14'h0) begin bad++; $display("FAIL reset_regs got=%0h exp=0", {a_int_level, a_int_vector, a_int_src}); end
    total++; if (b_int_req !== 1'b0) begin bad++; $display("FAIL reset_edge_int_req got=%0h exp=0", b_int_req); end
    // Requests present while reset is held must not be offered.
    reset = 1'b1; src_req = 8'hFF; src_level = 24'hFFFFFF;
    repeat (2) tick();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL reset_held_int_req got=%0h exp=0", a_int_req); end
    src_req = '0; src_level = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic_offer();
    do_reset();
    ipl = 3'd3; src_level[9 +: 3] = 3'd5; src_vector[24 +: 8] = 8'h30; src_req = 8'h08;
    tick();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL basic_early got=%0h exp=0", a_int_req); end
    tick();
    total++; if (a_int_req !== 1'b1) begin bad++; $display("FAIL basic_int_req got=%0h exp=1", a_int_req); end
    total++; if ({a_int_level, a_int_vector, a_int_src} !== {3'd5, 8'h30, 3'd3}) begin bad++; $display("FAIL basic_offer got=%0h exp=%0h", {a_int_level, a_int_vector, a_int_src}, {3'd5, 8'h30, 3'd3}); end
    src_vector[24 +: 8] = 8'h55;  // later vector change must not leak into the offer
    tick();
    total++; if (a_int_vector !== 8'h30 || a_int_req !== 1'b1) begin bad++; $display("FAIL basic_vec_frozen got=%0h/%0h exp=30/1", a_int_vector, a_int_req); end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0; src_req = 8'h00;
    total++; if (a_src_grant !== 8'h08 || a_int_req !== 1'b0) begin bad++; $display("FAIL basic_grant got=%0h/%0h exp=8/0", a_src_grant, a_int_req); end
    total++; if (b_src_grant !== 8'h08) begin bad++; $display("FAIL basic_edge_grant got=%0h exp=8", b_src_grant); end
    tick();
    total++; if (a_src_grant !== 8'h00) begin bad++; $display("FAIL basic_grant_pulse got=%0h exp=0", a_src_grant); end
    tick();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL basic_no_reoffer got=%0h exp=0", a_int_req); end
  endtask

  task automatic test_tie_break();
    do_reset();
    ipl = 3'd0;
    src_level[3 +: 3] = 3'd4; src_vector[8 +: 8] = 8'h11;
    src_level[18 +: 3] = 3'd4; src_vector[48 +: 8] = 8'h66;
    src_req = 8'h42;
    repeat (2) tick();
    total++; if (a_int_src !== 3'd1 || a_int_vector !== 8'h11) begin bad++; $display("FAIL tie_src got=%0h/%0h exp=1/11", a_int_src, a_int_vector); end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0; src_req = 8'h40;
    total++; if (a_src_grant !== 8'h02) begin bad++; $display("FAIL tie_grant got=%0h exp=2", a_src_grant); end
    tick();
    total++; if (a_int_req !== 1'b0 || a_src_grant !== 8'h00) begin bad++; $display("FAIL tie_dead_cycle got=%0h/%0h exp=0/0", a_int_req, a_src_grant); end
    tick();
    total++; if (a_int_req !== 1'b1 || a_int_src !== 3'd6 || a_int_vector !== 8'h66) begin bad++; $display("FAIL tie_next got=%0h/%0h/%0h exp=1/6/66", a_int_req, a_int_src, a_int_vector); end
    // A higher-level arrival must not preempt the frozen offer.
    src_level[21 +: 3] = 3'd7; src_req = 8'hC0;
    repeat (2) tick();
    total++; if (a_int_src !== 3'd6 || a_int_level !== 3'd4) begin bad++; $display("FAIL tie_no_preempt got=%0h/%0h exp=6/4", a_int_src, a_int_level); end
  endtask

  task automatic test_ipl_mask();
    do_reset();
    ipl = 3'd4; src_level[6 +: 3] = 3'd4; src_vector[16 +: 8] = 8'h22; src_req = 8'h04;
    repeat (3) tick();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL mask_equal_ipl got=%0h exp=0", a_int_req); end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    total++; if (a_src_grant !== 8'h00) begin bad++; $display("FAIL mask_ack_idle got=%0h exp=0", a_src_grant); end
    ipl = 3'd3;
    repeat (2) tick();
    total++; if (a_int_req !== 1'b1 || a_int_src !== 3'd2 || a_int_level !== 3'd4) begin bad++; $display("FAIL mask_offer got=%0h/%0h/%0h exp=1/2/4", a_int_req, a_int_src, a_int_level); end
    ipl = 3'd6;
    tick();
    total++; if (a_int_req !== 1'b0 || a_src_grant !== 8'h00) begin bad++; $display("FAIL mask_withdraw got=%0h/%0h exp=0/0", a_int_req, a_src_grant); end
    total++; if (a_int_src !== 3'd2 || a_int_vector !== 8'h22) begin bad++; $display("FAIL mask_hold got=%0h/%0h exp=2/22", a_int_src, a_int_vector); end
    do_reset();
    ipl = 3'd0; src_level[0 +: 3] = 3'd0; src_req = 8'h01;
    repeat (3) tick();
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL mask_level0 got=%0h exp=0", a_int_req); end
  endtask

  task automatic test_edge_mode();
    do_reset();
    ipl = 3'd7; src_level[15 +: 3] = 3'd7; src_vector[40 +: 8] = 8'h5A; src_req = 8'h20;
    tick();
    src_req = 8'h00;
    repeat (2) tick();
    total++; if (b_int_req !== 1'b0) begin bad++; $display("FAIL edge_masked got=%0h exp=0", b_int_req); end
    ipl = 3'd0;
    repeat (2) tick();
    total++; if (b_int_req !== 1'b1 || b_int_src !== 3'd5 || b_int_vector !== 8'h5A) begin bad++; $display("FAIL edge_offer got=%0h/%0h/%0h exp=1/5/5a", b_int_req, b_int_src, b_int_vector); end
    total++; if (a_int_req !== 1'b0) begin bad++; $display("FAIL edge_level_inst got=%0h exp=0", a_int_req); end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    total++; if (b_src_grant !== 8'h20) begin bad++; $display("FAIL edge_grant got=%0h exp=20", b_src_grant); end
    repeat (3) tick();
    total++; if (b_int_req !== 1'b0) begin bad++; $display("FAIL edge_no_reoffer got=%0h exp=0", b_int_req); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ipl = 3'd0; src_level[12 +: 3] = 3'd2; src_vector[32 +: 8] = 8'h44; src_req = 8'h10;
    repeat (2) tick();
    total++; if (a_int_req !== 1'b1 || a_int_src !== 3'd4) begin bad++; $display("FAIL b2b_offer got=%0h/%0h exp=1/4", a_int_req, a_int_src); end
    // Ack coincides with the winner becoming ineligible: the ack must win.
    cpu_ack = 1'b1; src_req = 8'h00; ipl = 3'd7;
    tick();
    cpu_ack = 1'b0;
    total++; if (a_src_grant !== 8'h10 || a_int_req !== 1'b0) begin bad++; $display("FAIL b2b_ack_wins got=%0h/%0h exp=10/0", a_src_grant, a_int_req); end
    reset = 1'b1;
    tick();
    total++; if ({a_int_req, a_src_grant, a_int_level, a_int_vector, a_int_src} !== 23'h0) begin bad++; $display("FAIL b2b_reset_in_grant got=%0h exp=0", {a_int_req, a_src_grant, a_int_level, a_int_vector, a_int_src}); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; src_req = '0; cpu_ack = 1'b0; ipl = '0;
    src_level = '0; src_vector = '0;
    test_reset();
    test_basic_offer();
    test_tie_break();
    test_ipl_mask();
    test_edge_mode();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
